mdu: RTL
========

# mdu

Multiply/divide unit for the EX stage, beside the ALU: same operand buses, owns the architectural HI/LO registers. Executes MIPS MULT/MULTU/DIV/DIVU with fixed multi-cycle latency and MTHI/MTLO in one cycle. Asserts `Busy` so the hazard unit stalls MFHI/MFLO and further MDU instructions in ID.

## Interface
- `MUL_CYCLES`, 5, Busy cycles for multiply ops (≥1)
- `DIV_CYCLES`, 10, Busy cycles for divide ops (≥1)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `A`  in  32  rs operand
- `B`  in  32  rt operand
- `Op`  in  4  MDU operation, valid when `Start`=1
- `Start`  in  1  one-cycle request from EX
- `Busy`  out  1  operation in flight
- `HI`  out  32  architectural HI
- `LO`  out  32  architectural LO

## Operation
- Op encoding: 0000 NOP, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO, 0111 MADD, 1000 MADDU, 1001 MSUB, 1010 MSUBU; others = NOP.
- States: IDLE, BUSY. Down-counter `cnt`, width from max(MUL_CYCLES, DIV_CYCLES).
- IDLE + `Start` + mul/div op: A, B latched; 64-bit result computed into pending `{hi_n, lo_n}`; `cnt` loaded with the op's cycle count; → BUSY.
- BUSY: `cnt` decrements each cycle; at `cnt`==1, `{HI,LO}` ← pending; → IDLE.
- MTHI/MTLO in IDLE: HI (or LO) ← A at that edge; no BUSY.
- `Start` while BUSY: ignored entirely (upstream must stall; bench checks no effect).
- MULT: signed 32×32→64, {HI,LO}. MULTU: unsigned.
- DIV: signed, quotient truncates toward zero → LO; remainder takes dividend's sign → HI. 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (B=0): full DIV_CYCLES busy, HI/LO unchanged at completion.
- Invalid/NOP op with `Start`: no state change.

## Timing
- Reset (async, `rst_n`=0): HI=0, LO=0, `Busy`=0, state IDLE, `cnt`=0, pending cleared. Reset mid-operation aborts; no commit.
- `Start` sampled at edge E0. `Busy` high cycles E0+1 … E0+N (N = MUL_CYCLES or DIV_CYCLES), registered output.
- HI/LO take new value at edge E0+N, same edge `Busy` falls: first cycle `Busy`=0, HI/LO are final.
- `Start` may be asserted in the cycle `Busy` falls (state IDLE by then); back-to-back ops allowed.
- MTHI/MTLO: visible the cycle after `Start`; `Busy` stays 0.
- HI/LO outputs stable (previous values) throughout BUSY.

## Configuration
- `MDU_MADD_EN` defined: MADD/MADDU/MSUB/MSUBU supported with MUL_CYCLES latency; `{HI,LO}` ← `{HI,LO}` ± product (signed or unsigned), mod 2^64, using HI/LO values at `Start`.
- Not defined: ops 0111–1010 decode as NOP; no accumulate adder synthesized.

## Structure
- Package `mdu_pkg`: Op encoding constants, state encoding (IDLE, BUSY), default cycle counts.
- One sub-module `mdu_core`: combinational 64-bit multiply / signed-unsigned divide producing pending {hi, lo} from A, B, Op, current HI/LO. Top holds FSM, counter, registers.

## Test plan
- MULT A=0xFFFFFFFF, B=2 → `Busy` 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 → `Busy` 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU with HI=0x11, LO=0x22 preloaded via MTHI/MTLO, B=0 → `Busy` 10 cycles, HI=0x11, LO=0x22 after.
- MULT started, then `Start` MTHI A=0xDEAD on busy cycle 2 → ignored; HI = product's high word at completion.
- `rst_n` low on busy cycle 3 of DIV → HI=LO=0, `Busy`=0 immediately; no later commit after reset released.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 → HI=1, LO=0 after 5 cycles; without macro same stimulus → no `Busy`, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - Op encodings carried on the 4-bit Op bus
//   - FSM state encoding (IDLE, BUSY)
//   - default busy latencies for multiply and divide
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU decode).
package mdu_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
    localparam logic [3:0] OP_MADD  = 4'b0111;
    localparam logic [3:0] OP_MADDU = 4'b1000;
    localparam logic [3:0] OP_MSUB  = 4'b1001;
    localparam logic [3:0] OP_MSUBU = 4'b1010;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mdu_core.sv
// mdu_core: combinational datapath of the multiply/divide unit.
// Produces the pending 64-bit {hi_n, lo_n} result for the operation on op.
// Ports:
//   a, b         in  32  rs / rt operands
//   op           in  4   MDU operation (mdu_pkg encoding)
//   hi_in, lo_in in  32  current architectural HI/LO (accumulate / divide-by-zero hold)
//   hi_n, lo_n   out 32  pending result to commit at end of the busy window
// Optional feature macro: MDU_MADD_EN (adds the 64-bit accumulate adder).
module mdu_core
    import mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n
);

    logic        is_signed_mul;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] q_s;
    logic [31:0] r_s;

    // Sign-extending to 64 bits and keeping the low 64 bits of an unsigned
    // product yields the exact two's-complement signed product.
    always_comb begin
        is_signed_mul = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
        a_ext = is_signed_mul ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext = is_signed_mul ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = a_ext * b_ext;
    end

    // Signed divide is done on magnitudes; quotient sign is the XOR of the
    // operand signs, remainder follows the dividend. 0x80000000 has no
    // positive counterpart but its unsigned magnitude is still correct.
    always_comb begin
        a_mag = a[31] ? (~a + 32'd1) : a;
        b_mag = b[31] ? (~b + 32'd1) : b;
        dvd   = (op == OP_DIV) ? a_mag : a;
        dvs   = (op == OP_DIV) ? b_mag : b;
        // Divisor forced to 1 when zero only to keep the divider defined;
        // the result is discarded in that case.
        if (dvs == 32'd0) begin
            dvs = 32'd1;
        end
        q_u = dvd / dvs;
        r_u = dvd % dvs;
        q_s = (a[31] ^ b[31]) ? (~q_u + 32'd1) : q_u;
        r_s = a[31] ? (~r_u + 32'd1) : r_u;
    end

`ifdef MDU_MADD_EN
    logic [63:0] acc;

    always_comb begin
        if ((op == OP_MSUB) || (op == OP_MSUBU)) begin
            acc = {hi_in, lo_in} - prod;
        end else begin
            acc = {hi_in, lo_in} + prod;
        end
    end
`endif

    always_comb begin
        hi_n = hi_in;
        lo_n = lo_in;
        case (op)
            OP_MULT, OP_MULTU: begin
                hi_n = prod[63:32];
                lo_n = prod[31:0];
            end
            OP_DIV: begin
                if (b != 32'd0) begin
                    hi_n = r_s;
                    lo_n = q_s;
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    hi_n = r_u;
                    lo_n = q_u;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                hi_n = acc[63:32];
                lo_n = acc[31:0];
            end
`endif
            default: begin
                hi_n = hi_in;
                lo_n = lo_in;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit beside the ALU; owns architectural HI/LO.
// Multi-cycle ops compute their result at Start into a pending register and
// commit it to HI/LO on the edge Busy falls. MTHI/MTLO write in one cycle.
// Ports:
//   clk    in  1   rising-edge clock
//   rst_n  in  1   asynchronous active-low reset
//   A, B   in  32  rs / rt operands
//   Op     in  4   operation, valid with Start
//   Start  in  1   one-cycle request (ignored while Busy)
//   Busy   out 1   operation in flight (registered)
//   HI, LO out 32  architectural HI/LO
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU; NOP otherwise).
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  Op,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;

    logic               is_mul;
    logic               is_div;
    logic [31:0]        core_hi;
    logic [31:0]        core_lo;

    mdu_core u_core (
        .a     (A),
        .b     (B),
        .op    (Op),
        .hi_in (hi_q),
        .lo_in (lo_q),
        .hi_n  (core_hi),
        .lo_n  (core_lo)
    );

    always_comb begin
        is_mul = (Op == OP_MULT) || (Op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (Op == OP_MADD) || (Op == OP_MADDU) ||
                 (Op == OP_MSUB) || (Op == OP_MSUBU);
`endif
        is_div = (Op == OP_DIV) || (Op == OP_DIVU);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (is_mul || is_div) begin
                        pend_hi_d = core_hi;
                        pend_lo_d = core_lo;
                        cnt_d     = is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_d   = BUSY;
                    end else if (Op == OP_MTHI) begin
                        hi_d = A;
                    end else if (Op == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            BUSY: begin
                // Start is deliberately not looked at here.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign Busy = (state_q == BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
